// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin front end sharing one external adder.
// One operation in flight; responses carry the owning requester id.
module adder_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         add_a_o,
    output logic [DATA_W-1:0]         add_b_o,
    input  logic [DATA_W:0]           add_sum_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W:0]           rsp_sum_o,
    output logic                      busy_o,
    output logic [31:0]               op_count_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    op_id;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;

    logic               hi_found;
    logic               lo_found;
    logic [ID_W-1:0]    hi_id;
    logic [ID_W-1:0]    lo_id;
    logic               any_req;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_vec;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

    // Round-robin pick: first valid at or above rr_ptr, else lowest valid.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && !hi_found && (ID_W'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_id    = ID_W'(i);
            end
            if (req_valid_i[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
            end
        end
        any_req   = lo_found;
        grant_id  = hi_found ? hi_id : lo_id;
        grant_vec = NUM_REQ'(1) << grant_id;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i]) begin
                sel_a = req_a_i[i*DATA_W +: DATA_W];
                sel_b = req_b_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant only while idle with a live request and not in reset.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && any_req && !rst_i) begin
            req_ready_o = grant_vec;
        end
    end

    assign add_a_o = op_a;
    assign add_b_o = op_b;
    assign busy_o  = (state != IDLE);

    // Control FSM: accept, capture adder result, hold until handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_id       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_sum_o   <= '0;
            op_count_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        op_id <= grant_id;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_o   <= add_sum_i;
                    rsp_id_o    <= op_id;
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        op_count_o  <= op_count_o + 32'd1;
                        if (op_id == ID_W'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= op_id + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed vectors with a response scoreboard.
// The bench models the shared adder as a plain 65-bit sum.
module tb_adder_share_arb;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   add_a;
    logic [DW-1:0]   add_b;
    logic [DW:0]     add_sum;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [DW:0]     rsp_sum;
    logic            busy;
    logic [31:0]     op_count;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    logic [66:0] exp_q[$];

    adder_share_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
        .req_ready_o(req_ready),
        .add_a_o(add_a), .add_b_o(add_b), .add_sum_i(add_sum),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum),
        .busy_o(busy), .op_count_o(op_count)
    );

    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [64:0] act,
                         input logic [64:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_op(input int n, input logic [63:0] a,
                          input logic [63:0] b);
        req_a[n*DW +: DW] = a;
        req_b[n*DW +: DW] = b;
    endtask

    task automatic push(input logic [1:0] id, input logic [64:0] s);
        exp_q.push_back({id, s});
    endtask

    task automatic wait_grant(input string nm, input logic [3:0] exp);
        int n = 0;
        @(negedge clk);
        while (req_ready == 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check(nm, req_ready, exp);
    endtask

    // Scoreboard monitor: pop on every response handshake.
    always @(negedge clk) begin
        logic [66:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got id %0d sum %0h expected none",
                         rsp_id, rsp_sum);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", rsp_id, e[66:65]);
                check("rsp_sum", rsp_sum, e[64:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int n;
        rst = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", op_count, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_id", rsp_id, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // single op with carry-out
        set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        req_valid = 4'b0001;
        push(2'd0, 65'h1_0000_0000_0000_0000);
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_calc_valid", rsp_valid, 0);
        check("t1_calc_busy", busy, 1);
        @(negedge clk);
        check("t1_latency", rsp_valid, 1);
        @(negedge clk);
        check("t1_count", op_count, 1);
        check("t1_idle", busy, 0);

        // round robin from a clean pointer
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) set_op(k, 64'(k), 64'(100 + k));
        push(2'd0, 65'd100);
        push(2'd1, 65'd102);
        push(2'd2, 65'd104);
        push(2'd3, 65'd106);
        push(2'd0, 65'd100);
        req_valid = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant("t2_grant", 4'(1 << (k % 4)));
            if (k > 0) check("t2_interval", 65'(cyc - last), 3);
            last = cyc;
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("t2_count", op_count, 5);

        // backpressure on req 1, req 2 waiting
        @(posedge clk); #1;
        set_op(1, 64'd10, 64'd20);
        push(2'd1, 65'd30);
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        wait_grant("t3_grant", 4'b0010);
        @(posedge clk); #1;
        req_valid = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t3_hold_sum", rsp_sum, 65'd30);
            check("t3_hold_id", rsp_id, 1);
            check("t3_hold_ready", req_ready, 0);
            check("t3_hold_busy", busy, 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("t3_idle", busy, 0);
        check("t3_valid_low", rsp_valid, 0);

        // pointer wrap: serve 2, then 3 before 1
        @(posedge clk); #1;
        set_op(2, 64'd1, 64'd2);
        push(2'd2, 65'd3);
        req_valid = 4'b0100;
        wait_grant("t4_grant2", 4'b0100);
        @(posedge clk); #1;
        set_op(3, 64'd1000, 64'd1);
        set_op(1, 64'd7, 64'd8);
        push(2'd3, 65'd1001);
        push(2'd1, 65'd15);
        req_valid = 4'b1010;
        wait_grant("t4_grant3", 4'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        wait_grant("t4_grant1", 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);

        // reset while holding a response
        @(posedge clk); #1;
        set_op(0, 64'd3, 64'd4);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_grant("t5_grant", 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        check("t5_in_resp", rsp_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_valid", rsp_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_count", op_count, 0);

        // operand isolation; grant 1 over 2 shows rr_ptr cleared
        @(posedge clk); #1;
        set_op(1, 64'd5, 64'd7);
        set_op(2, 64'd50, 64'd50);
        push(2'd1, 65'd12);
        req_valid = 4'b0110;
        wait_grant("t6_ptr_reset", 4'b0010);
        @(posedge clk); #1;
        set_op(1, 64'd99, 64'd99);
        req_valid = '0;
        @(negedge clk);
        check("t6_add_a", add_a, 5);
        check("t6_add_b", add_b, 7);
        @(negedge clk);
        check("t6_add_a_hold", add_a, 5);
        check("t6_add_b_hold", add_b, 7);
        @(negedge clk);
        check("t6_count", op_count, 1);

        repeat (2) @(negedge clk);
        check("sb_empty", 65'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
